// File: rtl/noc_switch_allocator_pkg.sv
// Shared types for the NoC switch allocator: output-port ownership states.
package Noc_parameters;

    typedef enum logic [0:0] {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } noc_sa_state_e;

endpackage

// File: rtl/noc_switch_allocator_rr_pick.sv
// Wrap-around priority pick: first requester strictly above last_grant,
// falling back to the lowest-indexed requester.
module noc_sa_rr_pick #(
    parameter int REQUESTS = 4
) (
    input  logic [REQUESTS-1:0] i_request,
    input  logic [REQUESTS-1:0] i_last_grant,
    output logic [REQUESTS-1:0] o_grant
);

    logic [REQUESTS-1:0] w_hi_mask;
    logic [REQUESTS-1:0] w_pool;

    // NOTE: combinational logic uses blocking assignments and assigns every
    // output a default first so no latch is inferred.
    always_comb begin
        logic w_seen;
        logic w_done;
        w_seen    = 1'b0;
        w_done    = 1'b0;
        w_hi_mask = '0;
        o_grant   = '0;
        for (int i = 0; i < REQUESTS; i++) begin
            w_hi_mask[i] = w_seen;
            w_seen       = w_seen | i_last_grant[i];
        end
        // Ports above the last winner take precedence; otherwise wrap to port 0.
        w_pool = (|(i_request & w_hi_mask)) ? (i_request & w_hi_mask) : i_request;
        for (int i = 0; i < REQUESTS; i++) begin
            if (w_pool[i] && !w_done) begin
                o_grant[i] = 1'b1;
                w_done     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// Credit-gated, packet-locking round-robin allocator for one NoC output port.
module noc_switch_allocator
    import Noc_parameters::*;
#(
    parameter int REQUESTS = 4,
    parameter int CREDITS  = 4
) (
    input  logic                         noc_clk,
    input  logic                         noc_rst,
    input  logic [REQUESTS-1:0]          in_valid,
    input  logic [REQUESTS-1:0]          in_last,
    output logic [REQUESTS-1:0]          in_ready,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [REQUESTS-1:0]          out_sel,
    input  logic                         credit_return,
    output logic [$clog2(CREDITS+1)-1:0] credit_count,
    output logic                         locked,
    output logic                         credit_err
);

    localparam int IDX_W = $clog2(REQUESTS);
    localparam int CW    = $clog2(CREDITS+1);

    noc_sa_state_e       r_state,      w_state_nxt;
    logic [IDX_W-1:0]    r_owner,      w_owner_nxt;
    logic [REQUESTS-1:0] r_last_grant, w_last_grant_nxt;
    logic [CW-1:0]       r_credit,     w_credit_nxt;
    logic                r_credit_err, w_credit_err_nxt;

    logic [REQUESTS-1:0] w_rr_grant;
    logic [REQUESTS-1:0] w_owner_oh;
    logic [REQUESTS-1:0] w_sel;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_xfer;

    noc_sa_rr_pick #(.REQUESTS(REQUESTS)) u_rr_pick (
        .i_request    (in_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_rr_grant)
    );

    assign w_owner_oh = REQUESTS'(1) << r_owner;

    // Transfer depends only on the registered credit count; reset kills it.
    always_comb begin
        w_sel = '0;
        if (!noc_rst && (r_credit != '0)) begin
            if (r_state == SA_IDLE) w_sel = w_rr_grant;
            else                    w_sel = w_owner_oh & in_valid;
        end
        w_sel_idx = '0;
        for (int i = 0; i < REQUESTS; i++) begin
            if (w_sel[i]) w_sel_idx = IDX_W'(i);
        end
    end

    assign w_xfer       = |w_sel;
    assign in_ready     = w_sel;
    assign out_sel      = w_sel;
    assign out_valid    = w_xfer;
    assign out_last     = |(w_sel & in_last);
    assign locked       = (r_state == SA_LOCKED);
    assign credit_count = r_credit;
    assign credit_err   = r_credit_err;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        if (w_xfer) begin
            case (r_state)
                SA_IDLE: begin
                    if (out_last) begin
                        w_last_grant_nxt = w_sel;
                    end else begin
                        w_state_nxt = SA_LOCKED;
                        w_owner_nxt = w_sel_idx;
                    end
                end
                SA_LOCKED: begin
                    if (out_last) begin
                        w_state_nxt      = SA_IDLE;
                        w_last_grant_nxt = w_owner_oh;
                    end
                end
                default: w_state_nxt = SA_IDLE;
            endcase
        end
    end

    // A return that coincides with a transfer cancels out and never overflows.
    always_comb begin
        w_credit_nxt     = r_credit;
        w_credit_err_nxt = r_credit_err;
        case ({w_xfer, credit_return})
            2'b10: w_credit_nxt = r_credit - CW'(1);
            2'b01: begin
                if (r_credit == CW'(CREDITS)) w_credit_err_nxt = 1'b1;
                else                          w_credit_nxt     = r_credit + CW'(1);
            end
            default: w_credit_nxt = r_credit;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled
    // synchronously on the clock edge.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_state      <= SA_IDLE;
            r_owner      <= '0;
            r_last_grant <= {1'b1, {(REQUESTS-1){1'b0}}};
            r_credit     <= CW'(CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_credit     <= w_credit_nxt;
            r_credit_err <= w_credit_err_nxt;
        end
    end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed testbench for noc_switch_allocator with REQUESTS=4, CREDITS=4.
module tb_noc_switch_allocator;

    logic       noc_clk = 1'b0;
    logic       noc_rst;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_last;
    logic [3:0] out_sel;
    logic       credit_return;
    logic [2:0] credit_count;
    logic       locked;
    logic       credit_err;

    int n_checks = 0;
    int n_errors = 0;

    noc_switch_allocator #(.REQUESTS(4), .CREDITS(4)) dut (
        .noc_clk       (noc_clk),
        .noc_rst       (noc_rst),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_sel       (out_sel),
        .credit_return (credit_return),
        .credit_count  (credit_count),
        .locked        (locked),
        .credit_err    (credit_err)
    );

    always #5 noc_clk = ~noc_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic test_reset();
        noc_rst = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; credit_return = 1'b0;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_in_ready: got %b expected 0000", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        tick(); tick();
        noc_rst = 1'b0; in_valid = 4'b0000;
        #1;
        n_checks++; if (credit_count !== 3'd4) begin n_errors++; $display("FAIL rst_credit: got %0d expected 4", credit_count); end
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL rst_locked: got %b expected 0", locked); end
        n_checks++; if (credit_err !== 1'b0) begin n_errors++; $display("FAIL rst_credit_err: got %b expected 0", credit_err); end
        n_checks++; if (out_sel !== 4'b0000) begin n_errors++; $display("FAIL rst_out_sel: got %b expected 0000", out_sel); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_sel [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            in_valid = 4'b1111; in_last = 4'b1111; credit_return = 1'b1;
            #1;
            n_checks++; if (out_sel !== exp_sel[i]) begin n_errors++; $display("FAIL rot_sel[%0d]: got %b expected %b", i, out_sel, exp_sel[i]); end
            n_checks++; if (in_ready !== exp_sel[i]) begin n_errors++; $display("FAIL rot_ready[%0d]: got %b expected %b", i, in_ready, exp_sel[i]); end
            n_checks++; if (out_last !== 1'b1) begin n_errors++; $display("FAIL rot_last[%0d]: got %b expected 1", i, out_last); end
            tick();
        end
        in_valid = 4'b0000; credit_return = 1'b0;
        #1;
        n_checks++; if (credit_count !== 3'd4) begin n_errors++; $display("FAIL rot_credit: got %0d expected 4", credit_count); end
        n_checks++; if (credit_err !== 1'b0) begin n_errors++; $display("FAIL rot_credit_err: got %b expected 0", credit_err); end
    endtask

    task automatic test_packet_lock();
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b1111; credit_return = 1'b1;
            in_last = (i == 2) ? 4'b0010 : 4'b0000;
            #1;
            n_checks++; if (out_sel !== 4'b0010) begin n_errors++; $display("FAIL lock_sel[%0d]: got %b expected 0010", i, out_sel); end
            n_checks++; if (out_last !== (i == 2)) begin n_errors++; $display("FAIL lock_last[%0d]: got %b expected %b", i, out_last, (i == 2)); end
            if (i > 0) begin
                n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_locked[%0d]: got %b expected 1", i, locked); end
            end
            tick();
        end
        in_last = 4'b1111;
        #1;
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_release: got %b expected 0", locked); end
        n_checks++; if (out_sel !== 4'b0100) begin n_errors++; $display("FAIL lock_next_sel: got %b expected 0100", out_sel); end
        tick();
    endtask

    task automatic test_credit_exhaustion();
        logic [3:0] exp_sel [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            in_valid = 4'b1111; in_last = 4'b1111; credit_return = 1'b0;
            #1;
            n_checks++; if (out_sel !== exp_sel[i]) begin n_errors++; $display("FAIL exh_sel[%0d]: got %b expected %b", i, out_sel, exp_sel[i]); end
            tick();
        end
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL exh_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL exh_in_ready: got %b expected 0000", in_ready); end
        n_checks++; if (credit_count !== 3'd0) begin n_errors++; $display("FAIL exh_credit: got %0d expected 0", credit_count); end
        tick();
        credit_return = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL exh_ret_at_zero: got %b expected 0", out_valid); end
        tick();
        credit_return = 1'b0;
        #1;
        n_checks++; if (credit_count !== 3'd1) begin n_errors++; $display("FAIL exh_credit_one: got %0d expected 1", credit_count); end
        n_checks++; if (out_sel !== 4'b1000) begin n_errors++; $display("FAIL exh_extra_sel: got %b expected 1000", out_sel); end
        tick();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL exh_after_extra: got %b expected 0", out_valid); end
        n_checks++; if (credit_count !== 3'd0) begin n_errors++; $display("FAIL exh_credit_end: got %0d expected 0", credit_count); end
    endtask

    task automatic test_simultaneous();
        in_valid = 4'b0000; credit_return = 1'b1;
        tick(); tick();
        n_checks++; if (credit_count !== 3'd2) begin n_errors++; $display("FAIL sim_credit_pre: got %0d expected 2", credit_count); end
        in_valid = 4'b1111; in_last = 4'b1111; credit_return = 1'b1;
        #1;
        n_checks++; if (out_sel !== 4'b0001) begin n_errors++; $display("FAIL sim_sel: got %b expected 0001", out_sel); end
        tick();
        in_valid = 4'b0000; credit_return = 1'b0;
        #1;
        n_checks++; if (credit_count !== 3'd2) begin n_errors++; $display("FAIL sim_credit_post: got %0d expected 2", credit_count); end
    endtask

    task automatic test_overflow();
        in_valid = 4'b0000; credit_return = 1'b1;
        tick(); tick();
        n_checks++; if (credit_count !== 3'd4) begin n_errors++; $display("FAIL ovf_credit_full: got %0d expected 4", credit_count); end
        n_checks++; if (credit_err !== 1'b0) begin n_errors++; $display("FAIL ovf_err_pre: got %b expected 0", credit_err); end
        tick();
        credit_return = 1'b0;
        #1;
        n_checks++; if (credit_count !== 3'd4) begin n_errors++; $display("FAIL ovf_credit_sat: got %0d expected 4", credit_count); end
        n_checks++; if (credit_err !== 1'b1) begin n_errors++; $display("FAIL ovf_err_set: got %b expected 1", credit_err); end
        tick(); tick(); tick();
        n_checks++; if (credit_err !== 1'b1) begin n_errors++; $display("FAIL ovf_err_sticky: got %b expected 1", credit_err); end
    endtask

    task automatic test_reset_mid_packet();
        in_valid = 4'b1000; in_last = 4'b0000; credit_return = 1'b0;
        #1;
        n_checks++; if (out_sel !== 4'b1000) begin n_errors++; $display("FAIL mid_first_sel: got %b expected 1000", out_sel); end
        tick();
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL mid_locked: got %b expected 1", locked); end
        noc_rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL mid_rst_ready: got %b expected 0000", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        tick();
        noc_rst = 1'b0; in_valid = 4'b0000;
        #1;
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL mid_unlocked: got %b expected 0", locked); end
        n_checks++; if (credit_count !== 3'd4) begin n_errors++; $display("FAIL mid_credit: got %0d expected 4", credit_count); end
        n_checks++; if (credit_err !== 1'b0) begin n_errors++; $display("FAIL mid_err_clear: got %b expected 0", credit_err); end
        in_valid = 4'b1111; in_last = 4'b1111;
        #1;
        n_checks++; if (out_sel !== 4'b0001) begin n_errors++; $display("FAIL mid_next_sel: got %b expected 0001", out_sel); end
        tick();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_packet_lock();
        test_credit_exhaustion();
        test_simultaneous();
        test_overflow();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_switch_allocator.md
NOC_SWITCH_ALLOCATOR -- requirements
Module: noc_switch_allocator

Interface
REQ-001 SHALL have parameter REQUESTS, default 4: number of input ports contending for one output port, at least 2.
REQ-002 SHALL have parameter CREDITS, default 4: downstream buffer depth in flits, at least 1.
REQ-003 SHALL have port noc_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port noc_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, REQUESTS: per-port flit available.
REQ-006 SHALL have port in_last, input, REQUESTS: per-port flit is the packet tail.
REQ-007 SHALL have port in_ready, output, REQUESTS: one-hot-or-zero; flit consumed when in_valid and in_ready are both 1.
REQ-008 SHALL have port out_valid, output, 1: flit forwarded this cycle.
REQ-009 SHALL have port out_last, output, 1: the forwarded flit is a tail.
REQ-010 SHALL have port out_sel, output, REQUESTS: one-hot datapath mux select, zero when out_valid is 0.
REQ-011 SHALL have port credit_return, input, 1: one downstream buffer slot freed.
REQ-012 SHALL have port credit_count, output, $clog2(CREDITS+1): current credits.
REQ-013 SHALL have port locked, output, 1: a multi-flit packet owns the output.
REQ-014 SHALL have port credit_err, output, 1: sticky flag, set by credit_return while credit_count equals CREDITS.

Function
REQ-015 SHALL implement a two-state machine: SA_IDLE (no owner) and SA_LOCKED (owner index held).
REQ-016 SHALL, in SA_IDLE with credit_count>0, select combinationally the first in_valid port scanning upward, with wrap-around, from the port after last_grant; in_ready, out_sel and out_valid are asserted in the same cycle (zero latency).
REQ-017 SHALL, in SA_IDLE, on a transfer with in_last=1, stay in SA_IDLE and set last_grant to the winner.
REQ-018 SHALL, in SA_IDLE, on a transfer with in_last=0, go to SA_LOCKED with owner set to the winner.
REQ-019 SHALL, in SA_LOCKED, assert in_ready only for the owner, and only while credit_count>0; other ports' in_valid is ignored.
REQ-020 SHALL, in SA_LOCKED, on an owner transfer with in_last=1, return to SA_IDLE and set last_grant to the owner.
REQ-021 SHALL, in SA_LOCKED, hold state when the owner has in_valid=0 (bubble); locked stays 1.
REQ-022 SHALL, when credit_count=0, assert no in_ready and no out_valid, and leave last_grant and the state unchanged.
REQ-023 SHALL update credit_count as: minus 1 on transfer; plus 1 on credit_return; unchanged when both occur in the same cycle.
REQ-024 SHALL saturate credit_count at CREDITS and set credit_err on an overflowing credit_return.
REQ-025 SHALL make the transfer condition depend only on the pre-update credit_count, so credit_return in the same cycle does not enable a transfer at count 0.
REQ-026 SHALL drive out_last as in_last of the selected port, and 0 when out_valid is 0.

Reset
REQ-027 SHALL, on noc_rst, set: state SA_IDLE; owner 0; last_grant = REQUESTS-1 (port 0 has highest priority first); credit_count = CREDITS; credit_err 0; locked 0.
REQ-028 SHALL, when noc_rst is asserted mid-packet, abandon the packet: no in_ready or out_valid during the reset cycle, and full credits afterwards.

Structure
REQ-029 SHALL place the state enum noc_sa_state_e (SA_IDLE, SA_LOCKED) in package Noc_parameters.
REQ-030 SHALL implement the wrap-around priority pick as one combinational sub-module, noc_sa_rr_pick (inputs: request, last_grant one-hot; output: grant one-hot).

Verification
REQ-031 SHALL verify single-flit rotation: in_valid=1111, in_last=1111 held, credits refilled each cycle -> grants to ports 0,1,2,3,0 on successive cycles.
REQ-032 SHALL verify packet lock: port 1 sends a 3-flit packet while in_valid=1111 -> out_sel=0010 for 3 consecutive transfers; next grant goes to port 2.
REQ-033 SHALL verify credit exhaustion: CREDITS=4, no credit_return, continuous traffic -> 4 transfers, then out_valid=0 and credit_count=0; one credit_return -> exactly one further transfer.
REQ-034 SHALL verify simultaneous credit_return and transfer at credit_count=2 -> credit_count stays 2; at credit_count=0 -> no transfer, and credit_count becomes 1.
REQ-035 SHALL verify overflow: credit_return at credit_count=4 -> credit_count stays 4, and credit_err=1 until reset.
REQ-036 SHALL verify reset mid-packet: noc_rst during flit 2 of port 3 -> locked=0, credit_count=4, and the next grant goes to port 0.
